// File: rtl/shift_receiver.sv
// Serial-to-parallel receiver for the data/clock/latch link: oversamples the
// three lines on i_clk, shifts MSB-first on rising serial clock, emits on latch.
module shift_receiver #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_serial_data,
  input  logic             i_serial_clk,
  input  logic             i_serial_latch,
  input  logic             i_clear_err,
  output logic [WIDTH-1:0] o_parallel_data,
  output logic             o_valid,
  output logic             o_frame_error,
  output logic             o_busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_OVF  = CNT_W'(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] latch_sync_q, latch_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   latch_prev_q, latch_prev_d;
  logic [WIDTH-1:0]       shift_q, shift_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]       par_q, par_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;

  logic data_s, sclk_s, latch_s;
  logic sclk_rise, latch_rise;
  logic err_set;

  // All three lines share the same synchronizer depth so they stay aligned.
  assign data_s     = data_sync_q[SYNC_STAGES-1];
  assign sclk_s     = sclk_sync_q[SYNC_STAGES-1];
  assign latch_s    = latch_sync_q[SYNC_STAGES-1];
  assign sclk_rise  = sclk_s & ~sclk_prev_q;
  assign latch_rise = latch_s & ~latch_prev_q;

  // Next-state and datapath update.
  always_comb begin
    state_d      = state_q;
    data_sync_d  = {data_sync_q[SYNC_STAGES-2:0], i_serial_data};
    sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], i_serial_clk};
    latch_sync_d = {latch_sync_q[SYNC_STAGES-2:0], i_serial_latch};
    sclk_prev_d  = sclk_s;
    latch_prev_d = latch_s;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    par_d        = par_q;
    valid_d      = 1'b0;
    err_set      = 1'b0;
    err_d        = err_q;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        // Latch has priority over a coincident serial clock edge.
        if (latch_rise) begin
          err_set = 1'b1;
          state_d = ST_HOLD;
        end else if (sclk_rise) begin
          shift_d = {shift_q[WIDTH-2:0], data_s};
          cnt_d   = CNT_W'(1);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (latch_rise) begin
          if (cnt_q == CNT_FULL) begin
            par_d   = shift_q;
            valid_d = 1'b1;
          end else begin
            err_set = 1'b1;
          end
          cnt_d   = '0;
          state_d = ST_HOLD;
        end else if (sclk_rise) begin
          shift_d = {shift_q[WIDTH-2:0], data_s};
          if (cnt_q != CNT_OVF) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_HOLD: begin
        if (!latch_s) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Sticky error: a set in the same cycle as a clear wins.
    if (i_clear_err) begin
      err_d = 1'b0;
    end
    if (err_set) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= ST_IDLE;
      data_sync_q  <= '0;
      sclk_sync_q  <= '0;
      latch_sync_q <= '0;
      sclk_prev_q  <= 1'b0;
      latch_prev_q <= 1'b0;
      shift_q      <= '0;
      cnt_q        <= '0;
      par_q        <= '0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_sync_q  <= data_sync_d;
      sclk_sync_q  <= sclk_sync_d;
      latch_sync_q <= latch_sync_d;
      sclk_prev_q  <= sclk_prev_d;
      latch_prev_q <= latch_prev_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      par_q        <= par_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
    end
  end

  assign o_parallel_data = par_q;
  assign o_valid         = valid_q;
  assign o_frame_error   = err_q;
  assign o_busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_shift_receiver.sv
// Directed bench for shift_receiver: good/short/long frames, HOLD clocks,
// mid-frame reset and a 256-word loopback from a bench-side transmitter.
module tb_shift_receiver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sdata, sclk, slatch, clr;
  logic [7:0] pdata;
  logic       valid, ferr, busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int valid_cyc = 0;
  int latch_cyc = 0;
  int v0;
  logic [7:0] rx[$];
  logic [7:0] sent[256];

  shift_receiver #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_serial_data  (sdata),
    .i_serial_clk   (sclk),
    .i_serial_latch (slatch),
    .i_clear_err    (clr),
    .o_parallel_data(pdata),
    .o_valid        (valid),
    .o_frame_error  (ferr),
    .o_busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every valid strobe, sampled on the falling edge.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      valid_cnt = valid_cnt + 1;
      valid_cyc = cyc;
      rx.push_back(pdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    assert (obs === exp) else begin
      n_err = n_err + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // MSB first; data changes with the falling serial clock, each level 4 cycles.
  task automatic send_bits(input logic [15:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sclk  = 1'b0;
      sdata = val[i];
      wait_cyc(4);
      sclk = 1'b1;
      wait_cyc(4);
    end
    sclk = 1'b0;
    wait_cyc(4);
  endtask

  task automatic do_latch(input int extra_clks);
    slatch    = 1'b1;
    latch_cyc = cyc;
    wait_cyc(4);
    for (int i = 0; i < extra_clks; i++) begin
      sclk = 1'b1;
      wait_cyc(4);
      sclk = 1'b0;
      wait_cyc(4);
    end
    slatch = 1'b0;
    wait_cyc(4);
  endtask

  task automatic pulse_clear();
    clr = 1'b1;
    wait_cyc(1);
    clr = 1'b0;
    wait_cyc(1);
  endtask

  initial begin
    rst_n  = 1'b0;
    sdata  = 1'b0;
    sclk   = 1'b0;
    slatch = 1'b0;
    clr    = 1'b0;
    wait_cyc(3);
    check("rst_data", 32'(pdata), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_err", 32'(ferr), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    wait_cyc(2);

    // Good frame 0xA5 with latency check
    v0 = valid_cnt;
    send_bits(16'h00A5, 8);
    check("a5_busy_mid", 32'(busy), 32'h1);
    do_latch(0);
    check("a5_data", 32'(pdata), 32'hA5);
    check("a5_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check("a5_latency", 32'(valid_cyc - latch_cyc), 32'd3);
    check("a5_err", 32'(ferr), 32'h0);
    check("a5_busy_end", 32'(busy), 32'h0);

    // Short frame after good 0x5A
    send_bits(16'h005A, 8);
    do_latch(0);
    check("5a_data", 32'(pdata), 32'h5A);
    v0 = valid_cnt;
    send_bits(16'h0033, 7);
    do_latch(0);
    check("short_err", 32'(ferr), 32'h1);
    check("short_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("short_data_kept", 32'(pdata), 32'h5A);
    pulse_clear();
    check("short_cleared", 32'(ferr), 32'h0);

    // Zero-bit frame from IDLE
    do_latch(0);
    check("zero_err", 32'(ferr), 32'h1);
    pulse_clear();

    // Long frame, then good 0x81 keeps sticky error
    v0 = valid_cnt;
    send_bits(16'h01FF, 9);
    do_latch(0);
    check("long_err", 32'(ferr), 32'h1);
    check("long_no_valid", 32'(valid_cnt - v0), 32'd0);
    send_bits(16'h0081, 8);
    do_latch(0);
    check("81_data", 32'(pdata), 32'h81);
    check("81_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check("81_err_sticky", 32'(ferr), 32'h1);
    pulse_clear();
    check("81_cleared", 32'(ferr), 32'h0);

    // Back-to-back frames with serial clocks during HOLD
    rx.delete();
    send_bits(16'h003C, 8);
    do_latch(2);
    send_bits(16'h00C3, 8);
    do_latch(0);
    check("b2b_count", 32'(rx.size()), 32'd2);
    if (rx.size() == 2) begin
      check("b2b_first", 32'(rx[0]), 32'h3C);
      check("b2b_second", 32'(rx[1]), 32'hC3);
    end
    check("b2b_err", 32'(ferr), 32'h0);

    // Asynchronous reset mid-frame
    send_bits(16'h000A, 4);
    #3 rst_n = 1'b0;
    #1;
    check("arst_data", 32'(pdata), 32'h0);
    check("arst_valid", 32'(valid), 32'h0);
    check("arst_err", 32'(ferr), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(2);
    v0 = valid_cnt;
    send_bits(16'h00FF, 8);
    do_latch(0);
    check("ff_data", 32'(pdata), 32'hFF);
    check("ff_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check("ff_err", 32'(ferr), 32'h0);

    // Loopback of 256 random words
    rx.delete();
    v0 = valid_cnt;
    for (int i = 0; i < 256; i++) begin
      sent[i] = 8'($urandom_range(0, 255));
      send_bits({8'h00, sent[i]}, 8);
      do_latch(0);
    end
    check("loop_valid_cnt", 32'(valid_cnt - v0), 32'd256);
    check("loop_err", 32'(ferr), 32'h0);
    check("loop_rx_size", 32'(rx.size()), 32'd256);
    if (rx.size() == 256) begin
      for (int i = 0; i < 256; i++) begin
        check("loop_word", 32'(rx[i]), 32'(sent[i]));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shift_receiver.md
Name: shift_receiver

Overview:
Serial-to-parallel receiver for the three-wire data/clock/latch interface that the clock's serial output path drives (MSB first, data changes on the falling serial clock, latch pulse ends the frame). It oversamples the external lines with i_clk and shifts data in on each rising serial clock. On the latch rising edge it presents a parallel word with a one-cycle valid strobe. It serves as the board-side or loopback end of the display/shift-register link and as a self-check monitor in the test harness.

Parameters:
WIDTH, 8, frame length in bits and parallel output width (WIDTH >= 2)
SYNC_STAGES, 2, synchronizer flops per serial input (>= 2)

Ports:
i_clk  input  1  system clock
i_reset_n  input  1  asynchronous active-low reset
i_serial_data  input  1  serial data line, MSB first
i_serial_clk  input  1  serial clock; data sampled on rising edge
i_serial_latch  input  1  latch line; rising edge ends the frame
i_clear_err  input  1  one-cycle pulse, clears o_frame_error
o_parallel_data  output  WIDTH  last correctly received word
o_valid  output  1  one-cycle strobe, new word on o_parallel_data
o_frame_error  output  1  sticky: latch arrived with bit count != WIDTH
o_busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset: asynchronous and active-low, via i_reset_n only. It clears the synchronizers, edge registers, shift register, bit counter and state (-> IDLE). o_parallel_data=0, o_valid=0, o_frame_error=0, o_busy=0. A reset mid-frame discards the partial frame.
- Input conditioning:
  - Each serial input passes through SYNC_STAGES flops, reset value 0. All three lines use equal depth, so they stay aligned.
  - Edge detect: synced value high and previous-cycle value low.
- Line timing requirements: each serial clock and latch level is held >= 2 i_clk cycles. Data is stable >= 1 i_clk cycle before and after a rising serial clock. Behaviour outside these limits is undefined.
- Shift register: on a rising serial clock edge that is accepted, the register loads {shift[WIDTH-2:0], data_sync}.
- Bit counter:
  - Width is clog2(WIDTH+2).
  - Increments on each accepted rising serial clock edge.
  - Saturates at WIDTH+1, which means overflow. No wrap.
- States:
  - IDLE: count=0. Rising serial clock -> shift the bit in, count=1, go to SHIFT. Rising latch -> frame error (zero-bit frame), go to HOLD.
  - SHIFT: rising serial clock -> shift the bit in and increment count. Rising latch:
    - If count==WIDTH: o_parallel_data <= shift register and o_valid=1 for exactly one cycle.
    - Otherwise: o_frame_error <= 1 and o_parallel_data is unchanged.
    - In both cases count <= 0 and the state goes to HOLD.
  - HOLD: latch still high. Rising serial clock edges are ignored (no shift, no count). Synced latch low -> IDLE.
- Simultaneous serial clock and latch rising edges in the same cycle: latch wins. The clock edge is dropped and not counted.
- o_frame_error is sticky:
  - Cleared by i_clear_err.
  - If set and clear happen in the same cycle, set wins.
  - A later good frame does not clear it.
- Latency: o_valid rises on the SYNC_STAGES-th rising i_clk edge after the edge that first samples i_serial_latch high. o_parallel_data updates on that same edge.
- o_busy = (state != IDLE). It is combinational from the state register.
- Shifting and latch detection need no software handshake. A new frame may begin as soon as HOLD returns to IDLE.

Test Plan:
- Reset, then send 0xA5 (8 rising serial clocks, data changing on falling edges, each level held 4 i_clk cycles), then latch -> o_parallel_data=0xA5, o_valid high exactly 1 cycle, exactly SYNC_STAGES edges after latch sampled, o_frame_error=0, o_busy back to 0.
- Send 7 bits then latch, after a prior good 0x5A -> o_frame_error=1, no o_valid, o_parallel_data stays 0x5A. Then pulse i_clear_err -> o_frame_error=0.
- Send 9 bits then latch -> o_frame_error=1, no o_valid. The next good 0x81 frame gives o_valid with 0x81, and o_frame_error stays 1 until cleared.
- Back-to-back frames 0x3C then 0xC3. Toggle serial clock twice while latch is high between the frames -> two o_valid pulses carrying 0x3C then 0xC3, and the extra clocks during HOLD are ignored.
- Assert i_reset_n low asynchronously after 4 bits of a frame -> all outputs 0 immediately. Then send a full frame 0xFF -> 0xFF with no error.
- Loopback: connect the existing serial transmitter, with its clock strobe every 4 i_clk cycles, to this block and send 256 random words -> every word is received in order, with 256 o_valid pulses and o_frame_error=0.
